serial_add_arbiter: RTL

Bit-serial adder controller that shares one 1-bit full-add datapath between two requesters. It arbitrates requests round-robin and captures the granted operands. The sum is computed LSB-first over W cycles, then the result is returned with an ID tag. It sits between the half-adder datapath cells and the blocks that need occasional W-bit additions without paying for a parallel adder each.

---
 rtl/serial_add_arbiter_if.sv | 33 +++
 rtl/serial_add_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter_if.sv
// Request/result bundle between two requesters and the shared
// bit-serial adder controller.
`timescale 1ns/1ps
interface serial_add_arbiter_if #(
   parameter int W = 8
);
   logic         req0;
   logic [W-1:0] a0;
   logic [W-1:0] b0;
   logic         req1;
   logic [W-1:0] a1;
   logic [W-1:0] b1;
   logic [1:0]   gnt;
   logic         busy;
   logic         done;
   logic         done_id;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output req0, a0, b0,
      output req1, a1, b1,
      input  gnt, busy, done,
      input  done_id, sum, cout
   );

   modport slave (
      input  req0, a0, b0,
      input  req1, a1, b1,
      output gnt, busy, done,
      output done_id, sum, cout
   );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of a single 1-bit full-adder datapath;
// operands are summed LSB-first over W cycles and returned with an ID.
`timescale 1ns/1ps
module serial_add_arbiter #(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_arbiter_if.slave bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_d;

   logic          ptr;
   logic          owner;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  res_q;
   logic          c_q;
   logic [CW-1:0] cnt;

   logic [1:0]    gnt_q;
   logic          busy_q;
   logic          done_q;
   logic          done_id_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;

   logic          grant;
   logic          pick1;
   logic          last;
   logic          s_bit;
   logic          c_nxt;
   logic [W-1:0]  msb;
   logic [W-1:0]  res_nxt;

   always_comb begin
      state_d = state;
      grant   = 1'b0;
      pick1   = 1'b0;
      last    = (cnt == CW'(W - 1));
      s_bit   = a_q[0] ^ b_q[0] ^ c_q;
      c_nxt   = (a_q[0] & b_q[0]) |
                (c_q & (a_q[0] ^ b_q[0]));
      msb        = '0;
      msb[W-1]   = s_bit;
      res_nxt    = (res_q >> 1) | msb;
      unique case (state)
         IDLE, DONE: begin
            // ptr set means requester 1 wins a tie
            if (bus.req0 | bus.req1) begin
               grant   = 1'b1;
               pick1   = bus.req1 & (~bus.req0 | ptr);
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (last) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= 1'b0;
         owner     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         c_q       <= 1'b0;
         cnt       <= '0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 1'b0;
         busy_q <= (state_d == SHIFT);
         if (grant) begin
            a_q   <= pick1 ? bus.a1 : bus.a0;
            b_q   <= pick1 ? bus.b1 : bus.b0;
            c_q   <= 1'b0;
            cnt   <= '0;
            gnt_q <= pick1 ? 2'b10 : 2'b01;
            owner <= pick1;
            ptr   <= ~pick1;
         end else if (state == SHIFT) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= c_nxt;
            res_q <= res_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
               done_q    <= 1'b1;
               sum_q     <= res_nxt;
               cout_q    <= c_nxt;
               done_id_q <= owner;
            end
         end
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
endmodule
